// File: rtl/fpgalink_pkg.sv
// Shared types and constants for the FX2 slave-FIFO channel command engine.
package fpgalink_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_LEN2,
        ST_LEN3,
        ST_WRITE,
        ST_TURN,
        ST_READ,
        ST_PKTEND
    } state_t;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_CHAN_MSB = 6;

    localparam logic [1:0] DEF_OUT_ADDR = 2'b00;
    localparam logic [1:0] DEF_IN_ADDR  = 2'b10;

endpackage

// File: rtl/fpgalink_chan_regs.sv
// Bank of 8-bit channel registers with per-channel write strobes and a read mux.
module fpgalink_chan_regs #(
    parameter int NUM_CHAN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [6:0]            idx,
    input  logic [7:0]            wdata,
    input  logic [6:0]            rd_idx,
    output logic [8*NUM_CHAN-1:0] chan_regs,
    output logic [NUM_CHAN-1:0]   wr_stb,
    output logic [7:0]            rdata
);

    // Indices at or above NUM_CHAN match no register, so such writes vanish
    // and such reads return 0x00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_regs <= '0;
            wr_stb    <= '0;
        end else begin
            wr_stb <= '0;
            for (int k = 0; k < NUM_CHAN; k++) begin
                if (we && (idx == 7'(k))) begin
                    chan_regs[8*k +: 8] <= wdata;
                    wr_stb[k]           <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (rd_idx == 7'(k)) rdata = chan_regs[8*k +: 8];
        end
    end

endmodule

// File: rtl/fpgalink_chan_ctrl.sv
// FX2 synchronous slave-FIFO command engine: framed reads/writes of a channel
// register bank over EP2 (OUT) and EP6 (IN).
module fpgalink_chan_ctrl
    import fpgalink_pkg::*;
#(
    parameter int         NUM_CHAN = 8,
    parameter int         LED_CHAN = 0,
    parameter int         PKT_SIZE = 512,
    parameter logic [1:0] OUT_ADDR = DEF_OUT_ADDR,
    parameter logic [1:0] IN_ADDR  = DEF_IN_ADDR
) (
    input  logic                  IFCLK,
    input  logic                  RST,
    input  logic                  FLAGB,
    input  logic                  FLAGC,
    input  logic [7:0]            FDI,
    output logic [7:0]            FDO,
    output logic                  FDS,
    output logic [1:0]            ADDR,
    output logic                  SLRD,
    output logic                  SLWR,
    output logic                  SLOE,
    output logic                  PKTEND,
    output logic [8*NUM_CHAN-1:0] CHAN_REGS,
    output logic [NUM_CHAN-1:0]   WR_STB,
    output logic [7:0]            LEDS
);

    localparam int PW = (PKT_SIZE > 1) ? $clog2(PKT_SIZE) : 1;

    state_t        state, nxt;
    logic [7:0]    cmd;
    logic [31:0]   len;
    logic [31:0]   len_full;
    logic [PW-1:0] pkt_cnt, pkt_nxt;
    logic [6:0]    chan;
    logic [7:0]    rdata;
    logic          we;

    assign chan     = cmd[CMD_CHAN_MSB:0];
    assign len_full = {len[23:0], FDI};
    assign pkt_nxt  = (PKT_SIZE > 1) ? pkt_cnt + 1'b1 : '0;
    assign we       = (state == ST_WRITE) && !SLRD;
    assign LEDS     = CHAN_REGS[8*LED_CHAN +: 8];

    always_comb begin
        nxt    = state;
        ADDR   = OUT_ADDR;
        SLRD   = 1'b1;
        SLWR   = 1'b1;
        SLOE   = 1'b1;
        PKTEND = 1'b1;
        FDS    = 1'b0;
        FDO    = 8'h00;
        case (state)
            ST_IDLE, ST_LEN0, ST_LEN1, ST_LEN2: begin
                SLOE = 1'b0;
                SLRD = !FLAGC;
                if (FLAGC) nxt = state_t'(state + 4'd1);
            end
            ST_LEN3: begin
                SLOE = 1'b0;
                SLRD = !FLAGC;
                if (FLAGC) begin
                    if (len_full == 32'd0)  nxt = ST_IDLE;
                    else if (cmd[CMD_WR_BIT]) nxt = ST_WRITE;
                    else                      nxt = ST_TURN;
                end
            end
            ST_WRITE: begin
                SLOE = 1'b0;
                SLRD = !FLAGC;
                if (FLAGC && (len == 32'd1)) nxt = ST_IDLE;
            end
            // Bus released for one cycle before the FPGA starts driving FDIO.
            ST_TURN: begin
                ADDR = IN_ADDR;
                nxt  = ST_READ;
            end
            ST_READ: begin
                ADDR = IN_ADDR;
                FDS  = 1'b1;
                FDO  = rdata;
                SLWR = !FLAGB;
                if (FLAGB && (len == 32'd1))
                    nxt = (pkt_nxt != '0) ? ST_PKTEND : ST_IDLE;
            end
            ST_PKTEND: begin
                ADDR   = IN_ADDR;
                PKTEND = 1'b0;
                nxt    = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
        // Keep every strobe inactive while reset is held, whatever the flags do.
        if (!RST) begin
            SLRD   = 1'b1;
            SLWR   = 1'b1;
            SLOE   = 1'b1;
            PKTEND = 1'b1;
            FDS    = 1'b0;
            FDO    = 8'h00;
        end
    end

    always_ff @(posedge IFCLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cmd     <= '0;
            len     <= '0;
            pkt_cnt <= '0;
        end else begin
            state <= nxt;
            case (state)
                ST_IDLE:                            if (!SLRD) cmd <= FDI;
                ST_LEN0, ST_LEN1, ST_LEN2, ST_LEN3: if (!SLRD) len <= len_full;
                ST_WRITE:                           if (!SLRD) len <= len - 32'd1;
                ST_READ: begin
                    if (!SLWR) begin
                        len     <= len - 32'd1;
                        pkt_cnt <= pkt_nxt;
                    end
                end
                ST_PKTEND: pkt_cnt <= '0;
                default: ;
            endcase
        end
    end

    fpgalink_chan_regs #(
        .NUM_CHAN (NUM_CHAN)
    ) u_regs (
        .clk       (IFCLK),
        .rst_n     (RST),
        .we        (we),
        .idx       (chan),
        .wdata     (FDI),
        .rd_idx    (chan),
        .chan_regs (CHAN_REGS),
        .wr_stb    (WR_STB),
        .rdata     (rdata)
    );

endmodule

// File: tb/tb_fpgalink_chan_ctrl.sv
// Directed bench for fpgalink_chan_ctrl: drives framed commands as the FX2 would.
module tb_fpgalink_chan_ctrl;

    logic        clk;
    logic        RST;
    logic        FLAGB;
    logic        FLAGC;
    logic [7:0]  FDI;
    logic [7:0]  FDO;
    logic        FDS;
    logic [1:0]  ADDR;
    logic        SLRD;
    logic        SLWR;
    logic        SLOE;
    logic        PKTEND;
    logic [63:0] CHAN_REGS;
    logic [7:0]  WR_STB;
    logic [7:0]  LEDS;

    int tests = 0;
    int fails = 0;

    int rd_cnt = 0;
    int wr_cnt = 0;
    int pe_cnt = 0;
    int stb_cnt = 0;
    int stb0_cnt = 0;
    int turn_cnt = 0;
    int bad_wr = 0;
    logic [7:0] fdo_q[$];

    fpgalink_chan_ctrl #(
        .NUM_CHAN (8),
        .LED_CHAN (0),
        .PKT_SIZE (512),
        .OUT_ADDR (2'b00),
        .IN_ADDR  (2'b10)
    ) dut (
        .IFCLK     (clk),
        .RST       (RST),
        .FLAGB     (FLAGB),
        .FLAGC     (FLAGC),
        .FDI       (FDI),
        .FDO       (FDO),
        .FDS       (FDS),
        .ADDR      (ADDR),
        .SLRD      (SLRD),
        .SLWR      (SLWR),
        .SLOE      (SLOE),
        .PKTEND    (PKTEND),
        .CHAN_REGS (CHAN_REGS),
        .WR_STB    (WR_STB),
        .LEDS      (LEDS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus monitor: counts transfers at each active edge.
    always @(posedge clk) begin
        if (SLRD === 1'b0) rd_cnt++;
        if (SLWR === 1'b0) begin
            wr_cnt++;
            fdo_q.push_back(FDO);
        end
        if (PKTEND === 1'b0) pe_cnt++;
        if (ADDR === 2'b10 && FDS === 1'b0 && PKTEND === 1'b1) turn_cnt++;
        if (FLAGB === 1'b0 && SLWR === 1'b0) bad_wr++;
        stb_cnt  += $countones(WR_STB);
        stb0_cnt += int'(WR_STB[0]);
    end

    task automatic put_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        FDI   = b;
        FLAGC = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (SLRD === 1'b0) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            fails++;
            $display("FAIL put_byte timeout: SLRD=%b, required 0", SLRD);
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] len,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input int ndata);
        logic [7:0] d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        put_byte(cmd);
        put_byte(len[31:24]);
        put_byte(len[23:16]);
        put_byte(len[15:8]);
        put_byte(len[7:0]);
        for (int i = 0; i < ndata; i++) put_byte(d[i]);
        @(negedge clk);
        FLAGC = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        for (int i = 0; i < 2000 && wr_cnt < target; i++) @(negedge clk);
        if (wr_cnt < target) begin
            fails++;
            $display("FAIL wait_writes timeout: writes=%0d, required %0d", wr_cnt, target);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; FLAGB = 1'b0; FLAGC = 1'b1; FDI = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (ADDR !== 2'b00) begin fails++; $display("FAIL rst_addr: got %b, required 00", ADDR); end
        tests++; if ({SLRD, SLWR, SLOE, PKTEND} !== 4'b1111) begin fails++; $display("FAIL rst_strobes: got %b, required 1111", {SLRD, SLWR, SLOE, PKTEND}); end
        tests++; if (FDS !== 1'b0 || FDO !== 8'h00) begin fails++; $display("FAIL rst_fd: got FDS=%b FDO=%h, required 0/00", FDS, FDO); end
        tests++; if (CHAN_REGS !== 64'h0 || WR_STB !== 8'h0 || LEDS !== 8'h0) begin fails++; $display("FAIL rst_regs: got %h/%h/%h, required 0", CHAN_REGS, WR_STB, LEDS); end
        FLAGC = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_led();
        int rb, sb;
        rb = rd_cnt; sb = stb0_cnt;
        send_frame(8'h80, 32'd1, 8'hA5, 8'h00, 8'h00, 1);
        repeat (3) @(negedge clk);
        tests++; if (rd_cnt - rb !== 6) begin fails++; $display("FAIL wled_reads: got %0d, required 6", rd_cnt - rb); end
        tests++; if (LEDS !== 8'hA5) begin fails++; $display("FAIL wled_leds: got %h, required a5", LEDS); end
        tests++; if (stb0_cnt - sb !== 1) begin fails++; $display("FAIL wled_stb0: got %0d, required 1", stb0_cnt - sb); end
    endtask

    task automatic test_write_read();
        int sb, tb0, wb, pb, qb;
        sb = stb_cnt;
        send_frame(8'h83, 32'd3, 8'h11, 8'h22, 8'h33, 3);
        repeat (3) @(negedge clk);
        tests++; if (CHAN_REGS[31:24] !== 8'h33) begin fails++; $display("FAIL wr3_reg: got %h, required 33", CHAN_REGS[31:24]); end
        tests++; if (stb_cnt - sb !== 3) begin fails++; $display("FAIL wr3_stb: got %0d, required 3", stb_cnt - sb); end
        tb0 = turn_cnt; wb = wr_cnt; pb = pe_cnt; qb = fdo_q.size();
        FLAGB = 1'b1;
        send_frame(8'h03, 32'd2, 8'h00, 8'h00, 8'h00, 0);
        wait_writes(wb + 2);
        repeat (4) @(negedge clk);
        FLAGB = 1'b0;
        tests++; if (turn_cnt - tb0 !== 1) begin fails++; $display("FAIL rd3_turn: got %0d, required 1", turn_cnt - tb0); end
        tests++; if (wr_cnt - wb !== 2) begin fails++; $display("FAIL rd3_writes: got %0d, required 2", wr_cnt - wb); end
        tests++; if (fdo_q.size() < qb + 2 || fdo_q[qb] !== 8'h33 || fdo_q[qb+1] !== 8'h33) begin fails++; $display("FAIL rd3_data: got %0d bytes, required 33 33", fdo_q.size() - qb); end
        tests++; if (pe_cnt - pb !== 1) begin fails++; $display("FAIL rd3_pktend: got %0d, required 1", pe_cnt - pb); end
    endtask

    task automatic test_stall();
        int wb, pb, bb, mid, qb;
        wb = wr_cnt; pb = pe_cnt; bb = bad_wr; qb = fdo_q.size();
        FLAGB = 1'b1;
        send_frame(8'h01, 32'd512, 8'h00, 8'h00, 8'h00, 0);
        wait_writes(wb + 100);
        FLAGB = 1'b0;
        mid = wr_cnt;
        repeat (5) @(negedge clk);
        tests++; if (wr_cnt !== mid) begin fails++; $display("FAIL stall_hold: got %0d writes, required %0d", wr_cnt, mid); end
        FLAGB = 1'b1;
        wait_writes(wb + 512);
        repeat (4) @(negedge clk);
        FLAGB = 1'b0;
        tests++; if (wr_cnt - wb !== 512) begin fails++; $display("FAIL stall_total: got %0d, required 512", wr_cnt - wb); end
        tests++; if (pe_cnt - pb !== 0) begin fails++; $display("FAIL stall_pktend: got %0d, required 0", pe_cnt - pb); end
        tests++; if (bad_wr - bb !== 0) begin fails++; $display("FAIL stall_slwr: got %0d writes with FLAGB low, required 0", bad_wr - bb); end
        tests++; if (fdo_q[qb + 511] !== 8'h00) begin fails++; $display("FAIL stall_data: got %h, required 00", fdo_q[qb + 511]); end
    endtask

    task automatic test_oob_chan();
        logic [63:0] snap;
        int rb, sb, wb, pb, qb;
        snap = CHAN_REGS; rb = rd_cnt; sb = stb_cnt;
        send_frame(8'hFF, 32'd2, 8'h5A, 8'h6B, 8'h00, 2);
        repeat (3) @(negedge clk);
        tests++; if (rd_cnt - rb !== 7) begin fails++; $display("FAIL oob_reads: got %0d, required 7", rd_cnt - rb); end
        tests++; if (stb_cnt - sb !== 0) begin fails++; $display("FAIL oob_stb: got %0d, required 0", stb_cnt - sb); end
        tests++; if (CHAN_REGS !== snap) begin fails++; $display("FAIL oob_regs: got %h, required %h", CHAN_REGS, snap); end
        wb = wr_cnt; pb = pe_cnt; qb = fdo_q.size();
        FLAGB = 1'b1;
        send_frame(8'h7F, 32'd1, 8'h00, 8'h00, 8'h00, 0);
        wait_writes(wb + 1);
        repeat (4) @(negedge clk);
        FLAGB = 1'b0;
        tests++; if (fdo_q.size() < qb + 1 || fdo_q[qb] !== 8'h00) begin fails++; $display("FAIL oob_read: got %0d bytes, required one 00", fdo_q.size() - qb); end
        tests++; if (pe_cnt - pb !== 1) begin fails++; $display("FAIL oob_pktend: got %0d, required 1", pe_cnt - pb); end
    endtask

    task automatic test_len_zero();
        int rb, sb, wb, pb;
        rb = rd_cnt; sb = stb_cnt; wb = wr_cnt; pb = pe_cnt;
        FLAGB = 1'b1;
        send_frame(8'h80, 32'd0, 8'h00, 8'h00, 8'h00, 0);
        repeat (4) @(negedge clk);
        FLAGB = 1'b0;
        tests++; if (rd_cnt - rb !== 5) begin fails++; $display("FAIL len0_reads: got %0d, required 5", rd_cnt - rb); end
        tests++; if (stb_cnt - sb !== 0 || wr_cnt - wb !== 0 || pe_cnt - pb !== 0) begin fails++; $display("FAIL len0_strobes: got stb=%0d wr=%0d pe=%0d, required 0", stb_cnt - sb, wr_cnt - wb, pe_cnt - pb); end
        send_frame(8'h82, 32'd1, 8'h5C, 8'h00, 8'h00, 1);
        repeat (3) @(negedge clk);
        tests++; if (CHAN_REGS[23:16] !== 8'h5C) begin fails++; $display("FAIL len0_next: got %h, required 5c", CHAN_REGS[23:16]); end
    endtask

    task automatic test_reset_mid();
        int rb;
        put_byte(8'h84);
        put_byte(8'h00);
        put_byte(8'h00);
        @(negedge clk);
        RST = 1'b0;
        #1;
        tests++; if ({SLRD, SLWR, SLOE, PKTEND, FDS} !== 5'b11110 || ADDR !== 2'b00) begin fails++; $display("FAIL rmid_ctrl: got %b addr=%b, required 11110 addr=00", {SLRD, SLWR, SLOE, PKTEND, FDS}, ADDR); end
        tests++; if (CHAN_REGS !== 64'h0 || LEDS !== 8'h0) begin fails++; $display("FAIL rmid_regs: got %h/%h, required 0", CHAN_REGS, LEDS); end
        FLAGC = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        rb = rd_cnt;
        send_frame(8'h84, 32'd1, 8'h77, 8'h00, 8'h00, 1);
        repeat (3) @(negedge clk);
        tests++; if (rd_cnt - rb !== 6) begin fails++; $display("FAIL rmid_reads: got %0d, required 6", rd_cnt - rb); end
        tests++; if (CHAN_REGS[39:32] !== 8'h77 || CHAN_REGS[7:0] !== 8'h00) begin fails++; $display("FAIL rmid_frame: got %h, required ch4=77 ch0=00", CHAN_REGS); end
    endtask

    initial begin
        RST = 1'b0; FLAGB = 1'b0; FLAGC = 1'b0; FDI = 8'h00;
        test_reset();
        test_write_led();
        test_write_read();
        test_stall();
        test_oob_chan();
        test_len_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpgalink_chan_ctrl.md
Name: fpgalink_chan_ctrl

Overview:
Parametrised FX2 synchronous slave-FIFO command engine. It replaces the fixed single-LED design with a bank of NUM_CHAN 8-bit channel registers that the host can write and read back. The host sends framed commands on EP2 (OUT); read data returns on EP6 (IN). A separate top-level wrapper owns the FDIO tri-state using FDI/FDO/FDS.

Parameters:
NUM_CHAN, 8, number of channel registers (1..128); channel index is cmd[6:0].
LED_CHAN, 0, channel whose register drives LEDS.
PKT_SIZE, 512, FX2 IN packet size in bytes (power of 2); used for PKTEND decisions.
OUT_ADDR, 2'b00, ADDR value selecting EP2.
IN_ADDR, 2'b10, ADDR value selecting EP6.

Ports:
IFCLK  in  1  FX2 interface clock; the only clock.
RST  in  1  reset, asynchronous, active-low.
FLAGB  in  1  EP6 has room (active-high).
FLAGC  in  1  EP2 has data (active-high).
FDI  in  8  data from FX2.
FDO  out  8  data to FX2.
FDS  out  1  1 = wrapper drives FDIO with FDO.
ADDR  out  2  FIFO select.
SLRD  out  1  FIFO read strobe, active-low.
SLWR  out  1  FIFO write strobe, active-low.
SLOE  out  1  FIFO output enable, active-low.
PKTEND  out  1  commit short packet, active-low.
CHAN_REGS  out  8*NUM_CHAN  flattened register bank; channel k occupies bits [8k+7:8k].
WR_STB  out  NUM_CHAN  one-cycle pulse on bit k for each byte written to channel k.
LEDS  out  8  equals CHAN_REGS for LED_CHAN.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, all registers 0x00, length=0, packet counter=0. ADDR=OUT_ADDR. SLRD=SLWR=SLOE=PKTEND=1. FDS=0, FDO=0x00, WR_STB=0.
- Strobes are combinational from the registered state and the flags. A byte is transferred on the rising edge where the strobe is 0. FDI is sampled on that same edge.
- Frame format: cmd byte (bit7: 1 = write, 0 = read; bits6:0 = chan), then a 32-bit length, big-endian (4 bytes), then length data bytes.
- IDLE, LEN0..LEN3: ADDR=OUT_ADDR, SLOE=0, SLRD=!FLAGC. Advance one state per accepted byte. Capture cmd in IDLE and the length bytes in LEN0..LEN3.
- After LEN3:
  - length==0: go to IDLE (no data phase, no PKTEND).
  - write: go to WRITE.
  - read: go to TURN.
- WRITE: ADDR=OUT_ADDR, SLOE=0, SLRD=!FLAGC.
  - Per accepted byte: length-1; if chan<NUM_CHAN, reg[chan]<=FDI and WR_STB[chan]=1 in the following cycle.
  - chan>=NUM_CHAN: byte is consumed and discarded, no strobe.
  - Last byte wins. Go to IDLE when length reaches 0.
- TURN: one cycle. ADDR=IN_ADDR, SLOE=1, FDS=0, no strobes. Guarantees no bus contention. Then go to READ.
- READ: ADDR=IN_ADDR, FDS=1, FDO=reg[chan] (0x00 if chan>=NUM_CHAN), SLWR=!FLAGB.
  - Per accepted byte: length-1; pkt_cnt=(pkt_cnt+1) mod PKT_SIZE.
  - Stall indefinitely while FLAGB=0.
  - At length 0: go to PKTEND if pkt_cnt!=0, else to IDLE.
- PKTEND: ADDR=IN_ADDR, PKTEND=0 for exactly one cycle, pkt_cnt<=0, then go to IDLE. In IDLE, FDS=0.
- Length is 32-bit and counts down. 0xFFFFFFFF must be accepted; no wrap below 0.
- FLAGC deasserting mid-frame: hold state, strobes high, resume when it returns.
- Reset mid-frame: partial frame is abandoned and registers are cleared.
- CHAN_REGS, WR_STB and LEDS are registered. LEDS updates one cycle after the accepting edge.

Decomposition:
- Package fpgalink_pkg holds:
  - state enum (IDLE, LEN0..LEN3, WRITE, TURN, READ, PKTEND);
  - cmd field constants (CMD_WR_BIT=7, CMD_CHAN_MSB=6);
  - default endpoint addresses.
- Sub-module fpgalink_chan_regs: register bank with write-enable/index/data in, and CHAN_REGS/WR_STB/read-mux out. The FSM, length counter and packet counter stay in the top.

Test Plan:
- Write cmd 0x80 (chan 0), len 1, data 0xA5 -> SLRD low for 6 accepted bytes; LEDS=0xA5; WR_STB[0] pulses once.
- Write chan 3, len 3, data 0x11,0x22,0x33, then read chan 3, len 2 -> exactly one idle TURN cycle before SLWR=0; two bytes 0x33,0x33 on FDO; PKTEND=0 for one cycle (pkt_cnt=2).
- Read chan 1, len 512, with FLAGB dropped for 5 cycles mid-transfer -> SLWR held high during the stall; 512 writes total; no PKTEND.
- Write to chan 0x7F with NUM_CHAN=8, len 2 -> both bytes consumed; no WR_STB; CHAN_REGS unchanged. A following read of 0x7F returns 0x00.
- Cmd with len 0 -> returns to IDLE; no data strobes; no PKTEND.
- Assert RST low during LEN2 -> all outputs at reset values immediately. The next full frame after release executes correctly.
